// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the push-button conditioning front end:
//   - debounce FSM state encoding
//   - default cycle constants for a 16 MHz clock
//   - counter width helper
// -----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 10 ms and 1 s at 16 MHz
    localparam int DEBOUNCE_10MS = 160000;
    localparam int LONG_1S       = 16000000;

    // Bits needed to hold the value n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input bit.
//
// Parameters:
//   RST_VAL  value both flops take during reset
// Ports:
//   CLK  in  destination clock
//   RST  in  asynchronous active-high reset
//   D    in  asynchronous input
//   Q    out synchronised output (two CLK cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic meta;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta <= RST_VAL;
            Q    <= RST_VAL;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Conditions a raw bouncing push-button pin into a synchronised, debounced
// pressed level plus one-cycle press / release event pulses.
//
// Optional feature macro: BUTTON_LONG_PRESS_EN
//   defined   -> BTN_LONG pulses once after LONG_CYCLES cycles held pressed
//   undefined -> BTN_LONG is constant 0 (port list unchanged)
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>= 1)
//   LONG_CYCLES      pressed cycles before BTN_LONG fires (>= 1)
//   ACTIVE_LOW       1 = pin reads 0 when pressed
// Ports:
//   CLK          in  system clock (rising edge)
//   RST          in  asynchronous active-high reset
//   PIN_IN       in  raw button pin, asynchronous to CLK
//   BTN_LEVEL    out debounced pressed level (1 = pressed)
//   BTN_PRESS    out one-cycle pulse on debounced 0->1
//   BTN_RELEASE  out one-cycle pulse on debounced 1->0
//   BTN_LONG     out one-cycle pulse on long-press event
//
// FSM states:
//   state           | meaning
//   ----------------+---------------------------------------------
//   ST_IDLE         | stable released
//   ST_PRESS_WAIT   | pin pressed, counting stable cycles
//   ST_PRESSED      | stable pressed
//   ST_RELEASE_WAIT | pin released, counting stable cycles
// -----------------------------------------------------------------------------
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int LONG_CYCLES     = LONG_1S,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic PIN_IN,
    output logic BTN_LEVEL,
    output logic BTN_PRESS,
    output logic BTN_RELEASE,
    output logic BTN_LONG
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("button_debounce: LONG_CYCLES must be >= 1");
    end

    localparam int             CNT_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             pin_pressed;
    logic             sync;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             press_accept;
    logic             release_accept;

    assign pin_pressed = ACTIVE_LOW ? ~PIN_IN : PIN_IN;

    // Reset value 0 = released, after the optional inversion.
    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (pin_pressed),
        .Q   (sync)
    );

    assign cnt_inc = cnt + CNT_W'(1);

    // The wait state is entered with cnt = 0 on the edge that first sees the
    // new level, so the terminal compare is made on the incremented value;
    // this places the accept edge exactly DEBOUNCE_CYCLES edges after sync
    // changed. With DEBOUNCE_CYCLES = 1 the wait state is skipped entirely.
    assign press_accept = sync &&
        ((state == ST_PRESS_WAIT && cnt_inc == CNT_TC) ||
         (state == ST_IDLE && DEBOUNCE_CYCLES == 1));

    assign release_accept = !sync &&
        ((state == ST_RELEASE_WAIT && cnt_inc == CNT_TC) ||
         (state == ST_PRESSED && DEBOUNCE_CYCLES == 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            BTN_LEVEL   <= 1'b0;
            BTN_PRESS   <= 1'b0;
            BTN_RELEASE <= 1'b0;
        end else begin
            BTN_PRESS   <= 1'b0;
            BTN_RELEASE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sync) begin
                        cnt <= '0;
                        if (press_accept) begin
                            state     <= ST_PRESSED;
                            BTN_LEVEL <= 1'b1;
                            BTN_PRESS <= 1'b1;
                        end else begin
                            state <= ST_PRESS_WAIT;
                        end
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!sync) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                        if (press_accept) begin
                            state     <= ST_PRESSED;
                            BTN_LEVEL <= 1'b1;
                            BTN_PRESS <= 1'b1;
                        end
                    end
                end
                ST_PRESSED: begin
                    if (!sync) begin
                        cnt <= '0;
                        if (release_accept) begin
                            state       <= ST_IDLE;
                            BTN_LEVEL   <= 1'b0;
                            BTN_RELEASE <= 1'b1;
                        end else begin
                            state <= ST_RELEASE_WAIT;
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    // A bounce back to pressed keeps the pressed state silently.
                    if (sync) begin
                        state <= ST_PRESSED;
                    end else begin
                        cnt <= cnt_inc;
                        if (release_accept) begin
                            state       <= ST_IDLE;
                            BTN_LEVEL   <= 1'b0;
                            BTN_RELEASE <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int              LCNT_W   = cnt_width(LONG_CYCLES + 1);
    localparam logic [LCNT_W-1:0] LCNT_TC  = LCNT_W'(LONG_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_SAT = LCNT_W'(LONG_CYCLES);

    logic [LCNT_W-1:0] lcnt;

    // lcnt parks at LCNT_SAT after firing so the event cannot repeat until a
    // fresh debounced press clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lcnt     <= '0;
            BTN_LONG <= 1'b0;
        end else begin
            BTN_LONG <= 1'b0;
            if (press_accept) begin
                lcnt <= '0;
            end else if (state == ST_PRESSED || state == ST_RELEASE_WAIT) begin
                if (lcnt == LCNT_TC) begin
                    BTN_LONG <= 1'b1;
                    lcnt     <= LCNT_SAT;
                end else if (lcnt != LCNT_SAT) begin
                    lcnt <= lcnt + LCNT_W'(1);
                end
            end
        end
    end
`else
    assign BTN_LONG = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

    localparam int DEB = 4;
    localparam int LNG = 20;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_LONG    = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic PIN_IN = 1'b0;
    logic BTN_LEVEL;
    logic BTN_PRESS;
    logic BTN_RELEASE;
    logic BTN_LONG;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG),
        .ACTIVE_LOW      (1'b0)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PIN_IN      (PIN_IN),
        .BTN_LEVEL   (BTN_LEVEL),
        .BTN_PRESS   (BTN_PRESS),
        .BTN_RELEASE (BTN_RELEASE),
        .BTN_LONG    (BTN_LONG)
    );

    always #5 CLK = ~CLK;

    // Rising edges seen so far; stimulus and monitor both act on negedges.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, required none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.at);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event pulse.
    always @(negedge CLK) begin
        if (!RST) begin
            check("press_release_exclusive", int'(BTN_PRESS & BTN_RELEASE), 0);
            if (BTN_PRESS) begin
                check("level_at_press", int'(BTN_LEVEL), 1);
                got(EV_PRESS);
            end
            if (BTN_RELEASE) begin
                check("level_at_release", int'(BTN_LEVEL), 0);
                got(EV_RELEASE);
            end
            if (BTN_LONG) begin
                got(EV_LONG);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        int c;

        // Reset state
        RST    = 1'b1;
        PIN_IN = 1'b0;
        wait_cycles(3);
        check("reset_level",   int'(BTN_LEVEL),   0);
        check("reset_press",   int'(BTN_PRESS),   0);
        check("reset_release", int'(BTN_RELEASE), 0);
        check("reset_long",    int'(BTN_LONG),    0);
        RST = 1'b0;
        wait_cycles(3);

        // Clean press held 40+ cycles: press at +6, long 20 after press
        PIN_IN = 1'b1;
        c = cyc;
        push(EV_PRESS, c + 6);
`ifdef BUTTON_LONG_PRESS_EN
        push(EV_LONG, c + 6 + LNG);
`endif
        wait_cycles(8);
        check("level_after_press", int'(BTN_LEVEL), 1);
        wait_cycles(38);
        check("level_held", int'(BTN_LEVEL), 1);

        // Release: release pulse at +6
        PIN_IN = 1'b0;
        c = cyc;
        push(EV_RELEASE, c + 6);
        wait_cycles(10);
        check("level_after_release", int'(BTN_LEVEL), 0);

        // Glitch of 3 cycles: no activity
        PIN_IN = 1'b1;
        wait_cycles(3);
        PIN_IN = 1'b0;
        wait_cycles(10);
        check("level_after_glitch", int'(BTN_LEVEL), 0);

        // Bounce 1,0,1,0,1 at 2-cycle intervals, then hold
        for (int i = 0; i < 5; i++) begin
            PIN_IN = (i % 2 == 0);
            if (i == 4) begin
                c = cyc;
                push(EV_PRESS, c + 6);
            end
            wait_cycles(2);
        end
        wait_cycles(8);
        check("level_after_bounce", int'(BTN_LEVEL), 1);

        // Bouncing release 0,1,0; completes before the long threshold
        PIN_IN = 1'b0;
        wait_cycles(2);
        PIN_IN = 1'b1;
        wait_cycles(2);
        PIN_IN = 1'b0;
        c = cyc;
        push(EV_RELEASE, c + 6);
        wait_cycles(10);
        check("level_after_bounce_release", int'(BTN_LEVEL), 0);
        wait_cycles(30);

        // Reset mid-hold
        PIN_IN = 1'b1;
        c = cyc;
        push(EV_PRESS, c + 6);
        wait_cycles(10);
        check("level_before_reset", int'(BTN_LEVEL), 1);
        RST = 1'b1;
        #1;
        check("midreset_level",   int'(BTN_LEVEL),   0);
        check("midreset_press",   int'(BTN_PRESS),   0);
        check("midreset_release", int'(BTN_RELEASE), 0);
        check("midreset_long",    int'(BTN_LONG),    0);
        wait_cycles(3);
        RST = 1'b0;
        c = cyc;
        push(EV_PRESS, c + 6);
`ifdef BUTTON_LONG_PRESS_EN
        push(EV_LONG, c + 6 + LNG);
`endif
        wait_cycles(40);
        check("level_after_reset_press", int'(BTN_LEVEL), 1);
        PIN_IN = 1'b0;
        c = cyc;
        push(EV_RELEASE, c + 6);
        wait_cycles(12);
        check("level_final", int'(BTN_LEVEL), 0);

        // Every expected event must have been seen
        check("events_outstanding", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
# button_debounce

Front-end conditioning stage for the board push-buttons. Takes a raw, asynchronous, bouncing pin (e.g. `PIN_1`) and delivers a synchronised, debounced level plus single-cycle press/release event pulses. A compile-time option adds a long-press event. Sits directly upstream of the LED toggle logic, which consumes `BTN_PRESS` instead of sampling the pin and edge-detecting itself.

## Interface
- `DEBOUNCE_CYCLES`, default 160000: consecutive stable cycles required to accept a level change (10 ms at 16 MHz); legal range ≥ 1.
- `LONG_CYCLES`, default 16000000: cycles held in the pressed state before `BTN_LONG` fires (1 s); legal range ≥ 1; used only with `BUTTON_LONG_PRESS_EN`.
- `ACTIVE_LOW`, default 0: 1 = pin reads 0 when pressed; the block inverts internally so "pressed" is always logic 1.
- `CLK` in 1: 16 MHz system clock; all logic is on its rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `PIN_IN` in 1: raw button pin, asynchronous to `CLK`.
- `BTN_LEVEL` out 1: debounced pressed level (1 = pressed).
- `BTN_PRESS` out 1: one-cycle pulse on the debounced 0→1 transition.
- `BTN_RELEASE` out 1: one-cycle pulse on the debounced 1→0 transition.
- `BTN_LONG` out 1: one-cycle pulse on a long-press event; tied 0 when the feature is compiled out.

## Operation
- The input path is `PIN_IN` → optional invert → 2-flop synchroniser → `sync`.
- The FSM has 4 states: IDLE (stable released), PRESS_WAIT, PRESSED (stable pressed), RELEASE_WAIT.
  - IDLE: when `sync` = 1, clear `cnt` and go to PRESS_WAIT.
  - PRESS_WAIT: when `sync` = 0, go back to IDLE (bounce rejected). Otherwise `cnt`++. When `cnt` = DEBOUNCE_CYCLES−1 and `sync` = 1, go to PRESSED, set `BTN_LEVEL` = 1 and pulse `BTN_PRESS`.
  - PRESSED: when `sync` = 0, clear `cnt` and go to RELEASE_WAIT.
  - RELEASE_WAIT: when `sync` = 1, go back to PRESSED (the pressed state is kept and no event fires). Otherwise `cnt`++. At the terminal count go to IDLE, set `BTN_LEVEL` = 0 and pulse `BTN_RELEASE`.
- `cnt` is sized to hold DEBOUNCE_CYCLES−1. It never wraps, because it is cleared on every state entry.
- Any glitch shorter than DEBOUNCE_CYCLES produces no output activity.
- Outputs are registered. `BTN_PRESS`, `BTN_RELEASE` and `BTN_LONG` are high for exactly one cycle per event.
- `BTN_PRESS` and `BTN_RELEASE` are never high in the same cycle.

## Timing
- Reset values: `BTN_LEVEL`, `BTN_PRESS`, `BTN_RELEASE` and `BTN_LONG` are 0. Synchroniser flops reset to 0 (released). FSM resets to IDLE. All counters reset to 0.
- Press latency: if `sync` first goes to 1 at edge *k* and stays there, `BTN_LEVEL` rises and `BTN_PRESS` pulses at edge *k*+DEBOUNCE_CYCLES. Measured from the pin, add 2 cycles of synchroniser delay.
- Release latency is symmetric to press latency.
- Reset mid-operation: all state is lost. If the pin is still held pressed after `RST` deasserts, the block treats it as a fresh press: a `BTN_PRESS` pulse follows after 2+DEBOUNCE_CYCLES cycles.
- Minimum event spacing is DEBOUNCE_CYCLES cycles, so back-to-back events cannot overlap.

## Configuration
- Macro: `BUTTON_LONG_PRESS_EN`.
- When defined:
  - A long counter `lcnt` clears on entry to PRESSED from PRESS_WAIT.
  - `lcnt` counts while the FSM is in PRESSED or RELEASE_WAIT.
  - When `lcnt` = LONG_CYCLES−1, `BTN_LONG` pulses once.
  - `lcnt` then saturates: there is no repeat until a debounced release followed by a new press.
  - A release that completes before the threshold suppresses `BTN_LONG`.
- When undefined: `lcnt` logic is absent and `BTN_LONG` is a constant 0. The port list is unchanged.

## Structure
- Shared package `button_pkg`:
  - FSM state encoding (IDLE/PRESS_WAIT/PRESSED/RELEASE_WAIT).
  - Default cycle constants for 16 MHz (`DEBOUNCE_10MS`, `LONG_1S`).
- One sub-module: `sync_2ff` (a 2-flop synchroniser with asynchronous reset and a reset value parameter). The team reuses it for other pins.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and LONG_CYCLES=20.
- Clean press: raise `PIN_IN` and hold it → `BTN_LEVEL`=1 and a single 1-cycle `BTN_PRESS` 6 cycles after the pin edge; no other pulses.
- Bounce: toggle `PIN_IN` 1,0,1,0,1 at 2-cycle intervals, then hold at 1 → no event during the bouncing; exactly one `BTN_PRESS` 6 cycles after the final rise.
- Glitch: drive `PIN_IN` high for 3 cycles, then low → `BTN_LEVEL` stays 0 and no pulses are produced.
- Release after a press: drop `PIN_IN` → one `BTN_RELEASE` 6 cycles later and `BTN_LEVEL`=0.
- Long press (macro defined): hold `PIN_IN` for 40 cycles → `BTN_LONG` pulses once, 20 cycles after `BTN_PRESS`, and not again. With the macro undefined, `BTN_LONG` stays 0.
- Reset mid-hold: assert `RST` while the button is pressed → all outputs go to 0 immediately; after deassert, with the pin still high, `BTN_PRESS` fires 6 cycles later.
